// File: rtl/fifo_rp_ctrl_pkg.sv
// fifo_rp_ctrl_pkg: shared constants, FSM encoding and depth helper for the FIFO pointer controller.
package fifo_rp_ctrl_pkg;
    localparam int ADDR_W_DEF = 8;
    localparam int DEPTH_DEF = 1 << ADDR_W_DEF;
    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;
    function automatic int depth_of(input int aw);
        return 1 << aw;
    endfunction
endpackage

// File: rtl/fifo_rp_ctrl_ptr_inc.sv
// fifo_rp_ctrl_ptr_inc: combinational modulo-2**W pointer increment.
module fifo_rp_ctrl_ptr_inc #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    output logic [W-1:0] y
);
    assign y = a + W'(1);
endmodule

// File: rtl/fifo_rp_ctrl.sv
// fifo_rp_ctrl: FIFO write pointer, occupancy and RP_Reg load control.
// Define FIFO_ERR_FLAGS_EN to add sticky ovf/udf error flags.
module fifo_rp_ctrl
    import fifo_rp_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic              flush,
    input  logic [ADDR_W-1:0] RP,
    output logic [ADDR_W-1:0] RP_next,
    output logic              RP_en,
    output logic [ADDR_W-1:0] WP,
    output logic              wr_en,
    output logic [ADDR_W:0]   count,
    output logic              empty,
    output logic              full,
    output logic              rd_valid
`ifdef FIFO_ERR_FLAGS_EN
    ,
    output logic              ovf,
    output logic              udf
`endif
);
    localparam int DEPTH = depth_of(ADDR_W);
    localparam logic [ADDR_W:0] ONE = 1;

    state_t state, state_next;
    logic wr_acc, rd_acc;
    logic [ADDR_W:0] count_next;
    logic [ADDR_W-1:0] wp_inc, rp_inc;

    fifo_rp_ctrl_ptr_inc #(.W(ADDR_W)) u_wp_inc (.a(WP), .y(wp_inc));
    fifo_rp_ctrl_ptr_inc #(.W(ADDR_W)) u_rp_inc (.a(RP), .y(rp_inc));

    assign empty   = count == '0;
    assign full    = count == DEPTH[ADDR_W:0];
    assign wr_acc  = !rst && wr_req && !full && !flush;
    assign rd_acc  = !rst && rd_req && !empty && !flush;
    assign wr_en   = wr_acc;
    assign RP_en   = !rst && (rd_acc || flush);
    assign RP_next = flush ? '0 : rp_inc;

    // ACTIVE is held while a read is accepted so its rd_valid strobe still lands
    always_comb begin
        count_next = (wr_acc && !rd_acc) ? count + ONE : (rd_acc && !wr_acc) ? count - ONE : count;
        state_next = flush ? IDLE : (state == IDLE) ? (wr_acc ? ACTIVE : IDLE) :
                     (count_next == '0 && !rd_acc) ? IDLE : ACTIVE;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            WP       <= '0;
            count    <= '0;
            rd_valid <= 1'b0;
            state    <= IDLE;
        end else begin
            if (wr_acc) WP <= wp_inc;
            count    <= count_next;
            rd_valid <= rd_acc && state == ACTIVE;
            state    <= state_next;
        end
    end

`ifdef FIFO_ERR_FLAGS_EN
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ovf <= 1'b0;
            udf <= 1'b0;
        end else begin
            ovf <= ovf || (wr_req && full);
            udf <= udf || (rd_req && empty);
        end
    end
`endif
endmodule

// File: tb/tb_fifo_rp_ctrl.sv
// tb_fifo_rp_ctrl: directed and randomized checks of fifo_rp_ctrl against a queue-based model.
module tb_fifo_rp_ctrl;
    localparam int DEPTH = 256;

    logic clk = 1'b0;
    logic rst, wr_req, rd_req, flush;
    logic [7:0] rp, RP_next, WP;
    logic RP_en, wr_en, empty, full, rd_valid;
    logic [8:0] count;
`ifdef FIFO_ERR_FLAGS_EN
    logic ovf, udf;
`endif

    int n_chk = 0;
    int n_fail = 0;
    int q[$];
    int m_wp = 0;
    bit m_rdv = 0;
    bit m_ovf = 0;
    bit m_udf = 0;

    always #5 clk = ~clk;

    fifo_rp_ctrl #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .rd_req(rd_req), .flush(flush),
        .RP(rp), .RP_next(RP_next), .RP_en(RP_en), .WP(WP), .wr_en(wr_en),
        .count(count), .empty(empty), .full(full), .rd_valid(rd_valid)
`ifdef FIFO_ERR_FLAGS_EN
        , .ovf(ovf), .udf(udf)
`endif
    );

    // stands in for the downstream RP_Reg
    always_ff @(posedge clk) begin
        if (rst) rp <= '0;
        else if (RP_en) rp <= RP_next;
    end

    function automatic bit exp_wacc();
        return !rst && !flush && wr_req && q.size() < DEPTH;
    endfunction

    function automatic bit exp_racc();
        return !rst && !flush && rd_req && q.size() > 0;
    endfunction

    task automatic drive(input logic w, input logic r, input logic f, input logic s);
        wr_req = w;
        rd_req = r;
        flush  = f;
        rst    = s;
        #1;
    endtask

    task automatic tick();
        bit wa, ra;
        wa = exp_wacc();
        ra = exp_racc();
        @(posedge clk);
        if (rst || flush) begin
            q.delete();
            m_wp = 0;
            m_rdv = 0;
            m_ovf = 0;
            m_udf = 0;
        end else begin
            m_ovf = m_ovf || (wr_req && q.size() == DEPTH);
            m_udf = m_udf || (rd_req && q.size() == 0);
            if (ra) void'(q.pop_front());
            if (wa) begin
                q.push_back(m_wp);
                m_wp = (m_wp + 1) % DEPTH;
            end
            m_rdv = ra;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 1);
        tick();
    endtask

    task automatic test_reset();
        drive(0, 0, 0, 1);
        tick();
        drive(0, 1, 0, 1);
        n_chk++; if (RP_en !== 1'b0) begin n_fail++; $display("FAIL rst_rp_en: got %b want 0", RP_en); end
        n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL rst_wr_en: got %b want 0", wr_en); end
        tick();
        drive(0, 0, 0, 0);
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rst_empty: got %b want 1", empty); end
        n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL rst_full: got %b want 0", full); end
        n_chk++; if (count !== 9'd0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", count); end
        n_chk++; if (WP !== 8'd0) begin n_fail++; $display("FAIL rst_wp: got %0d want 0", WP); end
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rd_valid: got %b want 0", rd_valid); end
        n_chk++; if (RP_en !== 1'b0) begin n_fail++; $display("FAIL rst_idle_rp_en: got %b want 0", RP_en); end
    endtask

    task automatic test_write_read();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            n_chk++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL wr3_wr_en[%0d]: got %b want 1", k, wr_en); end
            tick();
        end
        n_chk++; if (WP !== 8'd3) begin n_fail++; $display("FAIL wr3_wp: got %0d want 3", WP); end
        n_chk++; if (count !== 9'd3) begin n_fail++; $display("FAIL wr3_count: got %0d want 3", count); end
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0, 0);
            n_chk++; if (RP_en !== 1'b1) begin n_fail++; $display("FAIL rd3_rp_en[%0d]: got %b want 1", k, RP_en); end
            n_chk++; if (RP_next !== 8'(k + 1)) begin n_fail++; $display("FAIL rd3_rp_next[%0d]: got %0d want %0d", k, RP_next, k + 1); end
            n_chk++; if (rd_valid !== (k > 0)) begin n_fail++; $display("FAIL rd3_rd_valid[%0d]: got %b want %b", k, rd_valid, k > 0); end
            tick();
        end
        drive(0, 0, 0, 0);
        n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rd3_last_valid: got %b want 1", rd_valid); end
        n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL rd3_empty: got %b want 1", empty); end
        tick();
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rd3_valid_drop: got %b want 0", rd_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < DEPTH; k++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(1, 0, 0, 0);
        n_chk++; if (full !== 1'b1) begin n_fail++; $display("FAIL fill_full: got %b want 1", full); end
        n_chk++; if (count !== 9'd256) begin n_fail++; $display("FAIL fill_count: got %0d want 256", count); end
        n_chk++; if (WP !== 8'd0) begin n_fail++; $display("FAIL fill_wp_wrap: got %0d want 0", WP); end
        n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL fill_257_wr_en: got %b want 0", wr_en); end
        tick();
`ifdef FIFO_ERR_FLAGS_EN
        n_chk++; if (ovf !== 1'b1) begin n_fail++; $display("FAIL fill_ovf: got %b want 1", ovf); end
`endif
        drive(1, 1, 0, 0);
        n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL simfull_wr_en: got %b want 0", wr_en); end
        n_chk++; if (RP_en !== 1'b1) begin n_fail++; $display("FAIL simfull_rp_en: got %b want 1", RP_en); end
        tick();
        n_chk++; if (count !== 9'd255) begin n_fail++; $display("FAIL simfull_count: got %0d want 255", count); end
        n_chk++; if (full !== 1'b0) begin n_fail++; $display("FAIL simfull_full: got %b want 0", full); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(1, 1, 0, 0);
        n_chk++; if (wr_en !== 1'b1 || RP_en !== 1'b1) begin n_fail++; $display("FAIL sim5_accept: got wr_en=%b RP_en=%b want 1 1", wr_en, RP_en); end
        tick();
        n_chk++; if (count !== 9'd5) begin n_fail++; $display("FAIL sim5_count: got %0d want 5", count); end
        do_reset();
        drive(1, 1, 0, 0);
        n_chk++; if (wr_en !== 1'b1) begin n_fail++; $display("FAIL simempty_wr_en: got %b want 1", wr_en); end
        n_chk++; if (RP_en !== 1'b0) begin n_fail++; $display("FAIL simempty_rp_en: got %b want 0", RP_en); end
        tick();
        n_chk++; if (count !== 9'd1) begin n_fail++; $display("FAIL simempty_count: got %0d want 1", count); end
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL simempty_rd_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_empty_read();
        do_reset();
        drive(0, 1, 0, 0);
        n_chk++; if (RP_en !== 1'b0) begin n_fail++; $display("FAIL udf_rp_en: got %b want 0", RP_en); end
        tick();
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL udf_rd_valid: got %b want 0", rd_valid); end
        n_chk++; if (count !== 9'd0) begin n_fail++; $display("FAIL udf_count: got %0d want 0", count); end
`ifdef FIFO_ERR_FLAGS_EN
        n_chk++; if (udf !== 1'b1) begin n_fail++; $display("FAIL udf_flag: got %b want 1", udf); end
`endif
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 12; k++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0);
        n_chk++; if (count !== 9'd10 || rp !== 8'd2) begin n_fail++; $display("FAIL flush_pre: got count=%0d RP=%0d want 10 2", count, rp); end
        drive(1, 1, 1, 0);
        n_chk++; if (RP_en !== 1'b1) begin n_fail++; $display("FAIL flush_rp_en: got %b want 1", RP_en); end
        n_chk++; if (RP_next !== 8'd0) begin n_fail++; $display("FAIL flush_rp_next: got %0d want 0", RP_next); end
        n_chk++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL flush_wr_en: got %b want 0", wr_en); end
        tick();
        drive(0, 0, 0, 0);
        n_chk++; if (WP !== 8'd0) begin n_fail++; $display("FAIL flush_wp: got %0d want 0", WP); end
        n_chk++; if (count !== 9'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_rd_valid: got %b want 0", rd_valid); end
        n_chk++; if (rp !== 8'd0) begin n_fail++; $display("FAIL flush_rp: got %0d want 0", rp); end
    endtask

    task automatic test_rst_midstream();
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, 0, 0);
            tick();
        end
        drive(0, 1, 0, 0);
        tick();
        drive(0, 1, 0, 1);
        n_chk++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_valid_pre: got %b want 1", rd_valid); end
        n_chk++; if (RP_en !== 1'b0) begin n_fail++; $display("FAIL rstmid_rp_en: got %b want 0", RP_en); end
        tick();
        drive(0, 0, 0, 0);
        n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b want 0", rd_valid); end
        n_chk++; if (count !== 9'd0 || WP !== 8'd0) begin n_fail++; $display("FAIL rstmid_state: got count=%0d WP=%0d want 0 0", count, WP); end
    endtask

    task automatic test_random();
        logic [7:0] e_next;
        bit e_rpen, ph;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            ph = ((i / 600) % 2) == 0;
            drive($urandom_range(0, 99) < (ph ? 80 : 25), $urandom_range(0, 99) < (ph ? 25 : 80),
                  $urandom_range(0, 999) == 0, $urandom_range(0, 1999) == 0);
            e_rpen = !rst && (exp_racc() || flush);
            n_chk++; if (wr_en !== exp_wacc()) begin n_fail++; $display("FAIL rnd_wr_en @%0d: got %b want %b", i, wr_en, exp_wacc()); end
            n_chk++; if (RP_en !== e_rpen) begin n_fail++; $display("FAIL rnd_rp_en @%0d: got %b want %b", i, RP_en, e_rpen); end
            if (e_rpen) begin
                e_next = flush ? 8'd0 : 8'(q[0] + 1);
                n_chk++; if (RP_next !== e_next) begin n_fail++; $display("FAIL rnd_rp_next @%0d: got %0d want %0d", i, RP_next, e_next); end
            end
            if (exp_racc()) begin
                n_chk++; if (rp !== 8'(q[0])) begin n_fail++; $display("FAIL rnd_rd_addr @%0d: got %0d want %0d", i, rp, q[0]); end
            end
            n_chk++; if (count !== 9'(q.size())) begin n_fail++; $display("FAIL rnd_count @%0d: got %0d want %0d", i, count, q.size()); end
            n_chk++; if (WP !== 8'(m_wp)) begin n_fail++; $display("FAIL rnd_wp @%0d: got %0d want %0d", i, WP, m_wp); end
            n_chk++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_fail++; $display("FAIL rnd_flags @%0d: got empty=%b full=%b size %0d", i, empty, full, q.size()); end
            n_chk++; if (rd_valid !== m_rdv) begin n_fail++; $display("FAIL rnd_rd_valid @%0d: got %b want %b", i, rd_valid, m_rdv); end
`ifdef FIFO_ERR_FLAGS_EN
            n_chk++; if (ovf !== m_ovf || udf !== m_udf) begin n_fail++; $display("FAIL rnd_err @%0d: got ovf=%b udf=%b want %b %b", i, ovf, udf, m_ovf, m_udf); end
`endif
            tick();
        end
    endtask

    initial begin
        drive(0, 0, 0, 1);
        @(negedge clk);
        test_reset();
        test_write_read();
        test_fill();
        test_simultaneous();
        test_empty_read();
        test_flush();
        test_rst_midstream();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
